// File: rtl/pc_gen_ras.sv
// pc_gen_ras
// Program-counter generator at the head of the IF stage, with a small
// return-address stack (RAS) used to predict return targets at fetch.
//
// Next PC priority (first match wins): Reset, Trap, Redirect, Stall,
// RAS pop (when not empty), sequential increment.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   Reset          synchronous active-low reset (0 = reset)
//   Stall          hold PC and RAS this cycle
//   Trap           jump to TRAP_VECTOR and clear the RAS
//   Redirect       taken branch/jump; load Redirect_PC (word aligned)
//   Redirect_PC    redirect target
//   RAS_Push       a call was fetched; push RAS_Push_Addr
//   RAS_Push_Addr  return address to push
//   RAS_Pop        a return was fetched; next PC = RAS top
//   PC             current fetch PC (registered)
//   PC_Valid       PC is a valid fetch address (registered)
//   Misaligned     one-cycle pulse after a redirect with Redirect_PC[1:0] != 0
//   RAS_Empty      RAS count = 0
//   RAS_Full       RAS count = RAS_DEPTH
module pc_gen_ras #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Trap,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_PC,
  input  logic            RAS_Push,
  input  logic [XLEN-1:0] RAS_Push_Addr,
  input  logic            RAS_Pop,
  output logic [XLEN-1:0] PC,
  output logic            PC_Valid,
  output logic            Misaligned,
  output logic            RAS_Empty,
  output logic            RAS_Full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic            pc_valid_reg;
  logic            misaligned_reg, misaligned_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] top_addr;
  logic            ras_empty;
  logic            ras_full;

  assign ras_empty = (cnt_reg == '0);
  assign ras_full  = (cnt_reg == DEPTH_CNT);
  // Small stack: the top entry is read combinationally so a pop can
  // steer the very next PC.
  assign top_addr  = ras_mem[ptr_reg];

  always_comb begin
    pc_next         = pc_reg + INC_V;
    ptr_next        = ptr_reg;
    cnt_next        = cnt_reg;
    misaligned_next = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = ptr_reg + PTR_ONE;

    if (Trap) begin
      pc_next  = TRAP_VECTOR;
      cnt_next = '0;
    end else if (Redirect) begin
      pc_next         = {Redirect_PC[XLEN-1:2], 2'b00};
      misaligned_next = |Redirect_PC[1:0];
    end else if (Stall) begin
      pc_next = pc_reg;
    end else if (RAS_Pop && !ras_empty) begin
      pc_next = top_addr;
      if (RAS_Push) begin
        // Return and call together: the popped entry is replaced in place.
        wr_en  = 1'b1;
        wr_idx = ptr_reg;
      end else begin
        ptr_next = ptr_reg - PTR_ONE;
        cnt_next = cnt_reg - CNT_ONE;
      end
    end else if (RAS_Push) begin
      // Circular buffer: when full, the oldest entry is overwritten and
      // the count saturates.
      wr_en    = 1'b1;
      ptr_next = ptr_reg + PTR_ONE;
      if (!ras_full) begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_reg         <= RESET_VECTOR;
      pc_valid_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
    end else begin
      pc_reg         <= pc_next;
      pc_valid_reg   <= 1'b1;
      misaligned_reg <= misaligned_next;
      ptr_reg        <= ptr_next;
      cnt_reg        <= cnt_next;
    end
  end

  // Stack contents carry no reset; writes are blocked while in reset so a
  // push coincident with reset is discarded.
  always_ff @(posedge CLK) begin
    if (Reset && wr_en) begin
      ras_mem[wr_idx] <= RAS_Push_Addr;
    end
  end

  assign PC         = pc_reg;
  assign PC_Valid   = pc_valid_reg;
  assign Misaligned = misaligned_reg;
  assign RAS_Empty  = ras_empty;
  assign RAS_Full   = ras_full;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Trap;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        RAS_Push;
  logic [31:0] RAS_Push_Addr;
  logic        RAS_Pop;
  logic [31:0] PC;
  logic        PC_Valid;
  logic        Misaligned;
  logic        RAS_Empty;
  logic        RAS_Full;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t sb_q[$];

  pc_gen_ras dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Stall         (Stall),
    .Trap          (Trap),
    .Redirect      (Redirect),
    .Redirect_PC   (Redirect_PC),
    .RAS_Push      (RAS_Push),
    .RAS_Push_Addr (RAS_Push_Addr),
    .RAS_Pop       (RAS_Pop),
    .PC            (PC),
    .PC_Valid      (PC_Valid),
    .Misaligned    (Misaligned),
    .RAS_Empty     (RAS_Empty),
    .RAS_Full      (RAS_Full)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic idle();
    Stall         = 1'b0;
    Trap          = 1'b0;
    Redirect      = 1'b0;
    Redirect_PC   = 32'h0;
    RAS_Push      = 1'b0;
    RAS_Push_Addr = 32'h0;
    RAS_Pop       = 1'b0;
  endtask

  // Queue the expected post-edge state for the inputs currently driven,
  // clock once, then pop the scoreboard entry and compare.
  task automatic cyc(input string tag, input logic [31:0] e_pc, input logic e_val,
                     input logic e_mis, input logic e_emp, input logic e_full);
    exp_t e;
    exp_t got;
    sb_q.push_back('{pc: e_pc, valid: e_val, mis: e_mis, empty: e_emp, full: e_full});
    @(posedge CLK);
    #1;
    e   = sb_q.pop_front();
    got = '{pc: PC, valid: PC_Valid, mis: Misaligned, empty: RAS_Empty, full: RAS_Full};
    $display("txn %-12s PC=%08h V=%0b M=%0b E=%0b F=%0b", tag, PC, PC_Valid, Misaligned, RAS_Empty, RAS_Full);
    checks++;
    assert (got.pc === e.pc) else begin
      errors++;
      $error("FAIL %s.pc observed=%08h expected=%08h", tag, got.pc, e.pc);
    end
    checks++;
    assert (got.valid === e.valid) else begin
      errors++;
      $error("FAIL %s.valid observed=%0b expected=%0b", tag, got.valid, e.valid);
    end
    checks++;
    assert (got.mis === e.mis) else begin
      errors++;
      $error("FAIL %s.misaligned observed=%0b expected=%0b", tag, got.mis, e.mis);
    end
    checks++;
    assert (got.empty === e.empty) else begin
      errors++;
      $error("FAIL %s.empty observed=%0b expected=%0b", tag, got.empty, e.empty);
    end
    checks++;
    assert (got.full === e.full) else begin
      errors++;
      $error("FAIL %s.full observed=%0b expected=%0b", tag, got.full, e.full);
    end
    idle();
  endtask

  task automatic push(input logic [31:0] a);
    RAS_Push      = 1'b1;
    RAS_Push_Addr = a;
  endtask

  task automatic redir(input logic [31:0] a);
    Redirect    = 1'b1;
    Redirect_PC = a;
  endtask

  initial begin
    idle();
    Reset = 1'b0;

    // Reset and increment
    cyc("rst0", 32'h0, 0, 0, 1, 0);
    cyc("rst1", 32'h0, 0, 0, 1, 0);
    Reset = 1'b1;
    cyc("inc1", 32'h4, 1, 0, 1, 0);
    cyc("inc2", 32'h8, 1, 0, 1, 0);
    cyc("inc3", 32'hC, 1, 0, 1, 0);

    // Priority and stall
    Trap = 1'b1; redir(32'h2000);
    cyc("trap_redir", 32'h100, 1, 0, 1, 0);
    Trap = 1'b1; redir(32'h2003);
    cyc("trap_mis", 32'h100, 1, 0, 1, 0);
    redir(32'h2002);
    cyc("redir_mis", 32'h2000, 1, 1, 1, 0);
    Stall = 1'b1;
    cyc("stall1", 32'h2000, 1, 0, 1, 0);
    Stall = 1'b1;
    cyc("stall2", 32'h2000, 1, 0, 1, 0);
    Stall = 1'b1;
    cyc("stall3", 32'h2000, 1, 0, 1, 0);

    // RAS round trip
    push(32'h40);
    cyc("push40", 32'h2004, 1, 0, 0, 0);
    push(32'h80);
    cyc("push80", 32'h2008, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("pop80", 32'h80, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("pop40", 32'h40, 1, 0, 1, 0);
    RAS_Pop = 1'b1;
    cyc("pop_empty", 32'h44, 1, 0, 1, 0);

    // RAS overflow
    push(32'h10);
    cyc("ovf_p10", 32'h48, 1, 0, 0, 0);
    push(32'h20);
    cyc("ovf_p20", 32'h4C, 1, 0, 0, 0);
    push(32'h30);
    cyc("ovf_p30", 32'h50, 1, 0, 0, 0);
    push(32'h40);
    cyc("ovf_p40", 32'h54, 1, 0, 0, 1);
    push(32'h50);
    cyc("ovf_p50", 32'h58, 1, 0, 0, 1);
    RAS_Pop = 1'b1;
    cyc("ovf_pop50", 32'h50, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("ovf_pop40", 32'h40, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("ovf_pop30", 32'h30, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("ovf_pop20", 32'h20, 1, 0, 1, 0);

    // Simultaneous push+pop replaces top
    push(32'h40);
    cyc("sim_p40", 32'h24, 1, 0, 0, 0);
    push(32'h80);
    cyc("sim_p80", 32'h28, 1, 0, 0, 0);
    push(32'h90); RAS_Pop = 1'b1;
    cyc("sim_pushpop", 32'h80, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("sim_pop90", 32'h90, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("sim_pop40", 32'h40, 1, 0, 1, 0);

    // Push+pop on an empty stack behaves as a push
    push(32'h60); RAS_Pop = 1'b1;
    cyc("pp_empty", 32'h44, 1, 0, 0, 0);
    RAS_Pop = 1'b1;
    cyc("pp_pop60", 32'h60, 1, 0, 1, 0);

    // Push under stall is ignored
    push(32'h77); Stall = 1'b1;
    cyc("stall_push", 32'h60, 1, 0, 1, 0);
    RAS_Pop = 1'b1;
    cyc("stall_chk", 32'h64, 1, 0, 1, 0);

    // Trap clears a partly filled stack
    push(32'hA0);
    cyc("tr_pA0", 32'h68, 1, 0, 0, 0);
    push(32'hB0);
    cyc("tr_pB0", 32'h6C, 1, 0, 0, 0);
    push(32'hC0);
    cyc("tr_pC0", 32'h70, 1, 0, 0, 0);
    Trap = 1'b1;
    cyc("trap_clr", 32'h100, 1, 0, 1, 0);
    RAS_Pop = 1'b1;
    cyc("trap_pop", 32'h104, 1, 0, 1, 0);

    // Wrap-around
    redir(32'hFFFF_FFFC);
    cyc("wrap_redir", 32'hFFFF_FFFC, 1, 0, 1, 0);
    cyc("wrap_inc", 32'h0, 1, 0, 1, 0);

    // Reset mid-pop
    push(32'h300);
    cyc("rp_push", 32'h4, 1, 0, 0, 0);
    Reset = 1'b0; RAS_Pop = 1'b1;
    cyc("rst_pop", 32'h0, 0, 0, 1, 0);
    Reset = 1'b1;
    cyc("post_rst", 32'h4, 1, 0, 1, 0);
    RAS_Pop = 1'b1;
    cyc("post_pop", 32'h8, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
# pc_gen_ras

Parametrised program-counter generator for the pipelined RISC-V core. It holds the fetch PC and computes the next PC each cycle from trap, redirect, stall and sequential-increment requests. It also contains a small return-address stack (RAS) that predicts return targets at fetch. It sits at the head of the IF stage, feeding the instruction memory address and the IF/ID pipeline register.

## Interface

- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded while reset is asserted.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on Trap.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.

Ports:

- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset), sampled on the CLK rising edge.
- Stall  in  1  hold PC and RAS this cycle.
- Trap  in  1  jump to TRAP_VECTOR and clear the RAS.
- Redirect  in  1  branch/jump resolved taken; load Redirect_PC.
- Redirect_PC  in  XLEN  redirect target.
- RAS_Push  in  1  a call was fetched; push RAS_Push_Addr.
- RAS_Push_Addr  in  XLEN  return address to push.
- RAS_Pop  in  1  a return was fetched; next PC = RAS top.
- PC  out  XLEN  current fetch PC (registered).
- PC_Valid  out  1  PC is a valid fetch address (registered).
- Misaligned  out  1  one-cycle pulse: the last accepted Redirect_PC had bits [1:0] ≠ 0.
- RAS_Empty  out  1  RAS count = 0.
- RAS_Full  out  1  RAS count = RAS_DEPTH.

## Operation

Next-PC selection, in strict priority (first match wins):

1. Reset = 0 → PC = RESET_VECTOR.
2. Trap = 1 → PC = TRAP_VECTOR; RAS count → 0.
3. Redirect = 1 → PC = {Redirect_PC[XLEN-1:2], 2'b00}; Misaligned = |Redirect_PC[1:0].
4. Stall = 1 → PC holds.
5. RAS_Pop = 1 and not empty → PC = RAS top.
6. Otherwise → PC = PC + INC, modulo 2^XLEN (wraps silently).

RAS qualification:

- Push and pop take effect only when Reset = 1, Trap = 0, Redirect = 0 and Stall = 0. In any other case they are ignored.
- Storage is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
- Push only: write at top+1, advance the pointer, count += 1. When full, count saturates at RAS_DEPTH and the oldest entry is overwritten.
- Pop only, not empty: next PC = top, pointer −1, count −1.
- Pop when empty: no RAS change; next PC = PC + INC.
- Push and pop together, not empty: next PC = old top. The top entry is replaced by RAS_Push_Addr; pointer and count are unchanged.
- Push and pop together, empty: treat as push only; next PC = PC + INC.

Reset behaviour:

- PC = RESET_VECTOR, PC_Valid = 0, Misaligned = 0, RAS count = 0, pointer = 0.
- RAS_Empty = 1, RAS_Full = 0.
- RAS data contents are don't-care.

## Timing

- All outputs are registered. Inputs sampled at edge N take effect at PC after edge N; latency is 1 cycle.
- PC_Valid becomes 1 at the first edge with Reset = 1 and stays 1 until the next reset.
- Misaligned is high for exactly the cycle following the accepted redirect. A misaligned Redirect_PC that loses to Trap does not raise Misaligned.
- RAS_Empty and RAS_Full reflect the count after the edge.
- Reset asserted mid-operation overrides everything at that edge. A pending pop or push is discarded.
- Stall held for K cycles keeps PC, RAS state and Misaligned = 0 unchanged for K cycles.

## Test plan

- **Reset and increment:** Reset = 0 for 2 cycles, then 1 with no requests → PC = 0x0 with PC_Valid = 0, then 0x4 / 0x8 / 0xC with PC_Valid = 1.
- **Priority and stall:**
  - Trap and Redirect (0x2000) together → PC = 0x100, Misaligned = 0.
  - Redirect 0x2002 → PC = 0x2000, Misaligned = 1 for one cycle.
  - Stall for 3 cycles → PC holds at 0x2000.
- **RAS round trip:**
  - Push 0x40 then 0x80 → RAS_Empty = 0.
  - Pop → PC = 0x80.
  - Pop → PC = 0x40, RAS_Empty = 1.
  - Pop while empty → PC = 0x44.
- **RAS overflow:** with RAS_DEPTH = 4, push 0x10, 0x20, 0x30, 0x40, 0x50 → RAS_Full = 1. Four pops give PCs 0x50, 0x40, 0x30, 0x20, then RAS_Empty = 1.
- **Simultaneous and qualified ops:**
  - Top = 0x80; push 0x90 with pop → PC = 0x80, count unchanged, next pop → PC = 0x90.
  - Push with Stall = 1 → RAS unchanged.
  - Trap with count = 3 → RAS_Empty = 1.
- **Wrap-around and reset mid-pop:**
  - Redirect 0xFFFF_FFFC, then increment → PC = 0x0000_0000.
  - Reset = 0 coincident with Pop → PC = RESET_VECTOR, RAS_Empty = 1.
